// File: rtl/d_cache_ctrl_pkg.sv
// Shared definitions for the direct-mapped data cache controller:
// controller states and the line geometry (64 lines of 8 bytes).
package d_cache_ctrl_pkg;

   localparam int INDEX_W   = 6;
   localparam int OFFSET_W  = 3;
   localparam int NUM_LINES = 64;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      WB,
      REFILL,
      FILL,
      FL_CHECK,
      FL_WB,
      FL_DONE
   } state_t;

endpackage

// File: rtl/d_cache_tag_array.sv
// Per-line tag, valid and dirty flops for the data cache.
// Reads are combinational; a fill, clear or dirty-set writes the selected line.
module d_cache_tag_array
   import d_cache_ctrl_pkg::*;
#(
   parameter int TAG_W = 23
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INDEX_W-1:0] i_idx,
   input  logic               i_fillEn,
   input  logic [TAG_W-1:0]   i_fillTag,
   input  logic               i_setDirty,
   input  logic               i_clrEn,
   output logic [TAG_W-1:0]   o_rdTag,
   output logic               o_rdValid,
   output logic               o_rdDirty
);

   logic [NUM_LINES-1:0] r_valid;
   logic [NUM_LINES-1:0] r_dirty;
   logic [TAG_W-1:0]     r_tag [NUM_LINES];

   assign o_rdTag   = r_tag[i_idx];
   assign o_rdValid = r_valid[i_idx];
   assign o_rdDirty = r_dirty[i_idx];

   // Reset invalidates every line; the tags themselves are left untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (i_fillEn) begin
         r_valid[i_idx] <= 1'b1;
         r_dirty[i_idx] <= 1'b0;
      end else if (i_clrEn) begin
         r_valid[i_idx] <= 1'b0;
         r_dirty[i_idx] <= 1'b0;
      end else if (i_setDirty) begin
         r_dirty[i_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (i_fillEn) begin
         r_tag[i_idx] <= i_fillTag;
      end
   end

endmodule

// File: rtl/d_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller (64 x 8 bytes)
// driving an external data RAM with one-cycle read latency and a simple memory port.
module d_cache_ctrl
   import d_cache_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_we,
   input  logic [63:0]       req_wdata,
   input  logic [7:0]        req_wstrb,
   output logic              resp_valid,
   output logic [63:0]       resp_rdata,
   input  logic              flush_i,
   output logic              flush_done,
   output logic [5:0]        ram_addr,
   output logic [63:0]       ram_wdata,
   output logic [7:0]        ram_wen,
   input  logic [63:0]       ram_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [63:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [63:0]       mem_rdata
);

   localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

   state_t             r_state;
   state_t             w_next;
   logic [INDEX_W-1:0] r_idx;
   logic [INDEX_W-1:0] r_cnt;
   logic [TAG_W-1:0]   r_tag;
   logic               r_we;
   logic [63:0]        r_wdata;
   logic [7:0]         r_wstrb;
   logic [63:0]        r_victim;

   logic [INDEX_W-1:0] w_tagIdx;
   logic [TAG_W-1:0]   w_tagOut;
   logic               w_valid;
   logic               w_dirty;
   logic               w_hit;
   logic               w_fillEn;
   logic               w_setDirty;
   logic               w_clrEn;
   logic               w_flushing;
   logic               w_unusedOffset;

   assign w_unusedOffset = ^req_addr[OFFSET_W-1:0];
   assign w_flushing = (r_state == FL_CHECK) || (r_state == FL_WB) || (r_state == FL_DONE);
   assign w_tagIdx   = w_flushing ? r_cnt : r_idx;
   assign w_hit      = w_valid && (w_tagOut == r_tag);

   d_cache_tag_array #(
      .TAG_W(TAG_W)
   ) u_tagArray (
      .clk       (clk),
      .rst       (rst),
      .i_idx     (w_tagIdx),
      .i_fillEn  (w_fillEn),
      .i_fillTag (r_tag),
      .i_setDirty(w_setDirty),
      .i_clrEn   (w_clrEn),
      .o_rdTag   (w_tagOut),
      .o_rdValid (w_valid),
      .o_rdDirty (w_dirty)
   );

   // State register plus the request latch, victim capture and flush index counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_idx    <= '0;
         r_tag    <= '0;
         r_we     <= 1'b0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
         r_victim <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && flush_i) begin
            r_cnt <= '0;
         end else if (r_state == IDLE && req_valid) begin
            r_idx   <= req_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
            r_tag   <= req_addr[ADDR_W-1:INDEX_W+OFFSET_W];
            r_we    <= req_we;
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
         end
         if (r_state == LOOKUP && !w_hit) begin
            r_victim <= ram_rdata;
         end
         if (w_clrEn) begin
            r_cnt <= r_cnt + INDEX_W'(1);
         end
      end
   end

   // Next state and every output; the RAM is readdressed in FILL so LOOKUP sees the new line.
   always_comb begin
      w_next     = r_state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = '0;
      flush_done = 1'b0;
      ram_addr   = r_idx;
      ram_wdata  = '0;
      ram_wen    = '0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      w_fillEn   = 1'b0;
      w_setDirty = 1'b0;
      w_clrEn    = 1'b0;
      case (r_state)
         IDLE: begin
            ram_addr  = req_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
            req_ready = !flush_i;
            if (flush_i) begin
               w_next = FL_CHECK;
            end else if (req_valid) begin
               w_next = LOOKUP;
            end
         end
         LOOKUP: begin
            if (w_hit) begin
               resp_valid = 1'b1;
               w_next     = IDLE;
               if (r_we) begin
                  ram_wen    = r_wstrb;
                  ram_wdata  = r_wdata;
                  w_setDirty = 1'b1;
               end else begin
                  resp_rdata = ram_rdata;
               end
            end else begin
               w_next = (w_valid && w_dirty) ? WB : REFILL;
            end
         end
         WB: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {w_tagOut, r_idx, {OFFSET_W{1'b0}}};
            mem_wdata = r_victim;
            if (mem_ack) begin
               w_next = REFILL;
            end
         end
         REFILL: begin
            mem_req  = 1'b1;
            mem_addr = {r_tag, r_idx, {OFFSET_W{1'b0}}};
            if (mem_ack) begin
               ram_wdata = mem_rdata;
               ram_wen   = 8'hFF;
               w_fillEn  = 1'b1;
               w_next    = FILL;
            end
         end
         FILL: begin
            w_next = LOOKUP;
         end
         FL_CHECK: begin
            ram_addr = r_cnt;
            w_next   = FL_WB;
         end
         FL_WB: begin
            ram_addr = r_cnt;
            if (w_valid && w_dirty) begin
               mem_req   = 1'b1;
               mem_we    = 1'b1;
               mem_addr  = {w_tagOut, r_cnt, {OFFSET_W{1'b0}}};
               mem_wdata = ram_rdata;
            end
            if (!(w_valid && w_dirty) || mem_ack) begin
               w_clrEn = 1'b1;
               w_next  = (r_cnt == INDEX_W'(NUM_LINES - 1)) ? FL_DONE : FL_CHECK;
            end
         end
         FL_DONE: begin
            ram_addr   = r_cnt;
            flush_done = 1'b1;
            w_next     = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

endmodule

// File: doc/d_cache_ctrl.md
D_CACHE_CTRL -- requirements
Module: d_cache_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, physical address width.
REQ-002 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1: CPU access request.
REQ-005 SHALL have port req_ready, output, 1: controller can accept a request (IDLE only).
REQ-006 SHALL have port req_addr, input, ADDR_W: byte address.
- offset [2:0]; index [8:3]; tag [ADDR_W-1:9].
REQ-007 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_wdata, input, 64: store data.
REQ-009 SHALL have port req_wstrb, input, 8: store byte enables.
REQ-010 SHALL have port resp_valid, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, 64: line word; valid with resp_valid on loads.
REQ-012 SHALL have port flush_i, input, 1: request write-back and invalidate of all lines.
REQ-013 SHALL have port flush_done, output, 1: one-cycle pulse when flush completes.
REQ-014 SHALL have port ram_addr, output, 6: data RAM index.
REQ-015 SHALL have port ram_wdata, output, 64: data RAM write data.
REQ-016 SHALL have port ram_wen, output, 8: data RAM byte write enables.
REQ-017 SHALL have port ram_rdata, input, 64: data RAM read data; one-cycle registered latency.
REQ-018 SHALL have memory ports mem_req (output, 1), mem_we (output, 1), mem_addr (output, ADDR_W), mem_wdata (output, 64), mem_ack (input, 1), mem_rdata (input, 64).

Function
REQ-019 SHALL implement a direct-mapped, write-back, write-allocate cache of 64 lines x 8 bytes.
- Per-line tag, valid and dirty bits held in controller flops.
REQ-020 SHALL use states IDLE, LOOKUP, WB, REFILL, FILL, FL_CHECK, FL_WB, FL_DONE.
REQ-021 In IDLE, SHALL assert req_ready and drive ram_addr = req_addr[8:3].
- Accept on req_valid & req_ready; latch addr/we/wdata/wstrb; go to LOOKUP.
REQ-022 flush_i SHALL take priority over req_valid in IDLE.
- On flush, req_ready SHALL drop and the state SHALL go to FL_CHECK with index counter = 0.
REQ-023 In LOOKUP, hit = valid[idx] & tag match.
- Load hit: resp_valid = 1 and resp_rdata = ram_rdata in that cycle (1 cycle after accept).
- Store hit: ram_wen = latched wstrb, ram_wdata = latched wdata, dirty[idx] set, resp_valid = 1 same cycle.
- Either hit returns to IDLE.
REQ-024 On a LOOKUP miss, next state SHALL be WB if valid & dirty, else REFILL.
- Victim word SHALL be captured from ram_rdata.
REQ-025 In WB, SHALL issue a memory write.
- mem_we = 1, mem_addr = {old_tag, idx, 3'b000}, mem_wdata = victim.
- On mem_ack go to REFILL.
REQ-026 In REFILL, SHALL issue a memory read.
- mem_we = 0, mem_addr = {new_tag, idx, 3'b000}.
- On mem_ack: write mem_rdata with ram_wen = 8'hFF; set tag; valid = 1, dirty = 0; go to FILL.
REQ-027 FILL SHALL hold ram_addr = idx (RAM re-read) then return to LOOKUP, which now hits.
REQ-028 Handshake:
- mem_req SHALL hold its qualifiers stable until mem_ack (one-cycle pulse).
- mem_req SHALL deassert the cycle after mem_ack.
- mem_ack outside WB/REFILL/FL_WB SHALL be ignored.
REQ-029 Flush, per index: FL_CHECK sets ram_addr = cnt.
- Next cycle, if valid & dirty, FL_WB writes ram_rdata back to {tag, cnt, 3'b000}.
- valid and dirty cleared; cnt += 1; after cnt = 63 go to FL_DONE.
- FL_DONE pulses flush_done and returns to IDLE.
REQ-030 ram_wen SHALL be 0 in every state not listed in REQ-023/REQ-026.
REQ-031 At most one outstanding memory transaction; flush_i outside IDLE SHALL be ignored and must be held by the requester.

Reset
REQ-032 rst SHALL asynchronously force:
- state IDLE; all valid/dirty = 0.
- mem_req = 0, resp_valid = 0, flush_done = 0, ram_wen = 0, cnt = 0.
- Tags unchanged; data RAM contents are not reset.
REQ-033 rst mid-transaction SHALL abandon it with no response; a late mem_ack SHALL be ignored.

Structure
REQ-034 A shared package SHALL hold the state enum, index/offset widths (6/3) and line count 64.
REQ-035 The sub-module d_cache_tag_array SHALL contain the tag/valid/dirty flops; the FSM stays in d_cache_ctrl.

Verification
REQ-036 Cold load 0x0000_0100 with mem_rdata 0x1122334455667788 -> exactly one memory read, to 0x100, then resp_rdata 0x1122334455667788.
REQ-037 Load hit on the same address -> resp_valid exactly 1 cycle after accept, no mem_req.
REQ-038 Store 0x100, wstrb 8'h0F, wdata 0xAABBCCDD -> load returns 0x11223344AABBCCDD and the line is dirty.
REQ-039 Load 0x0000_0300 (same index 0x20, new tag) -> memory write to 0x100 of 0x11223344AABBCCDD, then memory read to 0x300.
REQ-040 Flush with 3 dirty lines -> exactly 3 memory writes, one flush_done pulse, then all lines invalid.
REQ-041 rst asserted while waiting for mem_ack in REFILL -> mem_req low immediately; the next load to that address misses.
